// File: rtl/instr_fetch_pkg.sv
// Shared types for the fetch stage: word type, FIFO entry layout, FSM states.
package instr_fetch_pkg;

    typedef logic [31:0] t_word;

    typedef struct packed {
        t_word instr;
        t_word pc;
    } t_fetch_entry;

    typedef enum logic {
        FS_FETCH = 1'b0,
        FS_DRAIN = 1'b1
    } t_fetch_state;

    localparam int unsigned INSTR_BYTES = 4;

    // Clear the byte-offset bits so every fetch address is word aligned.
    function automatic t_word align_word(input t_word a);
        return a & ~t_word'(INSTR_BYTES - 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; power-of-two depth, pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push, do_pop;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];
    // Guards keep the pointers consistent even if a caller misbehaves.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Storage and pointer update; flush discards contents but keeps stale data words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues credit-limited imem reads, buffers in-order
// responses and hands {instr, pc} to the decoder. Redirects flush and drain.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter t_word RESET_PC   = 32'h0000_0000,
    parameter int    FIFO_DEPTH = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    output logic  imem_req_valid,
    input  logic  imem_req_ready,
    output t_word imem_req_addr,
    input  logic  imem_rsp_valid,
    input  t_word imem_rsp_data,
    output logic  instr_valid,
    input  logic  instr_ready,
    output t_word instr,
    output t_word instr_pc,
    input  logic  redirect_valid,
    input  t_word redirect_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    t_fetch_state  state;
    t_word         req_pc, rsp_pc;
    logic [CW-1:0] outstanding, discard, occupancy, rsp_dec, stale;
    logic [CW:0]   in_flight;
    logic          credit, req_fire;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    t_fetch_entry  push_entry, head;

    // Every request must have a guaranteed FIFO slot: in-flight plus buffered <= depth.
    assign in_flight = {1'b0, outstanding} + {1'b0, occupancy};
    assign credit    = !fifo_full && (in_flight < (CW+1)'(FIFO_DEPTH));

    assign imem_req_valid = rst_n && (state == FS_FETCH) && !redirect_valid && credit;
    assign imem_req_addr  = rst_n ? req_pc : RESET_PC;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses are only kept in FETCH; the redirect cycle and DRAIN drop them.
    assign fifo_push  = (state == FS_FETCH) && !redirect_valid && imem_rsp_valid;
    assign push_entry = '{instr: imem_rsp_data, pc: rsp_pc};

    assign instr_valid = rst_n && !fifo_empty;
    assign instr       = rst_n ? head.instr : '0;
    assign instr_pc    = rst_n ? head.pc    : '0;
    assign fifo_pop    = instr_valid && instr_ready;

    // Responses still owed after a redirect, excluding one returning this cycle.
    assign rsp_dec = CW'(imem_rsp_valid);
    assign stale   = outstanding - rsp_dec;

    sync_fifo #(
        .WIDTH ($bits(t_fetch_entry)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (occupancy)
    );

    // PC, credit and FSM update; redirect overrides everything but reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FS_FETCH;
            req_pc      <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect_valid) begin
            req_pc      <= align_word(redirect_pc);
            rsp_pc      <= align_word(redirect_pc);
            outstanding <= stale;
            discard     <= stale;
            state       <= (stale != '0) ? FS_DRAIN : FS_FETCH;
        end else if (state == FS_FETCH) begin
            if (req_fire)       req_pc <= req_pc + t_word'(INSTR_BYTES);
            if (imem_rsp_valid) rsp_pc <= rsp_pc + t_word'(INSTR_BYTES);
            outstanding <= outstanding + CW'(req_fire) - rsp_dec;
        end else if (imem_rsp_valid) begin
            outstanding <= outstanding - CW'(1);
            discard     <= discard - CW'(1);
            if (discard == CW'(1)) state <= FS_FETCH;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: in-order memory model with fixed latency,
// decoder/request monitors and hand-computed expected values.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam t_word KEY = 32'h1357_9BDF;  // memory returns addr ^ KEY

    logic  clk = 1'b0;
    logic  rst_n;
    logic  imem_req_valid, imem_req_ready;
    t_word imem_req_addr;
    logic  imem_rsp_valid = 1'b0;
    t_word imem_rsp_data  = '0;
    logic  instr_valid, instr_ready;
    t_word instr, instr_pc;
    logic  redirect_valid;
    t_word redirect_pc;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat     = 1;
    logic ovf   = 1'b0;

    t_word mq_addr [$];
    int    mq_t    [$];
    t_word iss_q   [$];
    t_word got_pc  [$];
    t_word got_ins [$];

    instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic t_word qget(input t_word q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    // Memory model, request/decoder monitors and overflow watch at the clock edge.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            mq_addr.delete();
            mq_t.delete();
        end else begin
            if (imem_rsp_valid && mq_addr.size() > 0) begin
                void'(mq_addr.pop_front());
                void'(mq_t.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                mq_addr.push_back(imem_req_addr);
                mq_t.push_back(cyc);
                iss_q.push_back(imem_req_addr);
            end
            if (instr_valid && instr_ready) begin
                got_pc.push_back(instr_pc);
                got_ins.push_back(instr);
            end
            if (dut.fifo_push && dut.fifo_full) ovf = 1'b1;
        end
    end

    // Response driver: head of queue returns once its latency has elapsed.
    initial forever begin
        @(negedge clk);
        if (rst_n && mq_addr.size() > 0 && (cyc - mq_t[0]) >= lat - 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq_addr[0] ^ KEY;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    task automatic clear_logs;
        iss_q.delete();
        got_pc.delete();
        got_ins.delete();
    endtask

    // Leaves rst_n low at a negedge; caller releases it.
    task automatic reset_dut;
        @(negedge clk);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        clear_logs();
    endtask

    initial begin
        logic [19:0] pat;
        logic        pv, pr;
        t_word       pa;
        rst_n = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;

        // 1: reset values, then streaming with 1-cycle memory
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 0);
        chk("rst_instr_valid", 32'(instr_valid), 0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        rst_n = 1'b1; #1;
        chk("t1_first_req_valid", 32'(imem_req_valid), 1);
        chk("t1_first_req_addr", imem_req_addr, 32'h0);
        @(negedge clk); #1;
        chk("t1_c1_addr", imem_req_addr, 32'h4);
        chk("t1_c1_no_bypass", 32'(instr_valid), 0);
        @(negedge clk); #1;
        chk("t1_c2_instr_valid", 32'(instr_valid), 1);
        chk("t1_c2_pc", instr_pc, 32'h0);
        chk("t1_c2_instr", instr, 32'h0 ^ KEY);
        chk("t1_c2_credit_stall", 32'(imem_req_valid), 0);
        @(negedge clk); #1;
        chk("t1_c3_pc", instr_pc, 32'h4);
        chk("t1_c3_addr", imem_req_addr, 32'h8);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("t1_issue_seq", qget(iss_q, i), t_word'(4 * i));
            chk("t1_deliver_pc", qget(got_pc, i), t_word'(4 * i));
            chk("t1_deliver_instr", qget(got_ins, i), t_word'(4 * i) ^ KEY);
        end

        // 2: decoder stalled -> only FIFO_DEPTH requests, then drain and resume
        reset_dut();
        instr_ready = 1'b0;
        rst_n = 1'b1;
        repeat (8) @(negedge clk); #1;
        chk("t2_issue_cnt", 32'(iss_q.size()), 2);
        chk("t2_req_blocked", 32'(imem_req_valid), 0);
        chk("t2_fifo_full", 32'(dut.fifo_full), 1);
        chk("t2_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("t2_drain0", qget(got_pc, 0), 32'h0);
        chk("t2_drain1", qget(got_pc, 1), 32'h4);
        chk("t2_resume_pc", qget(got_pc, 2), 32'h8);
        chk("t2_resume_issue", qget(iss_q, 2), 32'h8);

        // 3: imem_req_ready toggling -> stable address, no skips or repeats
        reset_dut();
        pat = 20'b1010_0110_0011_1001_0110;
        pv = 1'b0; pr = 1'b1; pa = '0;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            imem_req_ready = pat[i];
            #1;
            if (pv && !pr) begin
                chk("t3_valid_held", 32'(imem_req_valid), 1);
                chk("t3_addr_stable", imem_req_addr, pa);
            end
            pv = imem_req_valid; pr = imem_req_ready; pa = imem_req_addr;
            @(negedge clk);
        end
        imem_req_ready = 1'b1;
        repeat (12) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("t3_issue_seq", qget(iss_q, i), t_word'(4 * i));
            chk("t3_deliver_pc", qget(got_pc, i), t_word'(4 * i));
        end

        // 4: redirect with two requests outstanding, latency 3
        reset_dut();
        lat = 3;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t4_outstanding", 32'(dut.outstanding), 2);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102; #1;
        chk("t4_no_req_in_R", 32'(imem_req_valid), 0);
        @(negedge clk);
        redirect_valid = 1'b0; #1;
        chk("t4_state_drain", 32'(dut.state), 32'(FS_DRAIN));
        chk("t4_discard", 32'(dut.discard), 2);
        chk("t4_addr_aligned", imem_req_addr, 32'h0000_0100);
        chk("t4_drain_no_req", 32'(imem_req_valid), 0);
        @(negedge clk); #1;
        chk("t4_drain2_no_req", 32'(imem_req_valid), 0);
        chk("t4_drain_no_instr", 32'(instr_valid), 0);
        @(negedge clk); #1;
        chk("t4_state_fetch", 32'(dut.state), 32'(FS_FETCH));
        chk("t4_resume_valid", 32'(imem_req_valid), 1);
        chk("t4_resume_addr", imem_req_addr, 32'h0000_0100);
        repeat (10) @(negedge clk);
        chk("t4_first_pc", qget(got_pc, 0), 32'h0000_0100);
        chk("t4_first_instr", qget(got_ins, 0), 32'h0000_0100 ^ KEY);

        // 5: redirect coincident with a response, one more outstanding
        reset_dut();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        @(negedge clk);
        redirect_valid = 1'b0; #1;
        chk("t5_discard", 32'(dut.discard), 1);
        chk("t5_outstanding", 32'(dut.outstanding), 1);
        chk("t5_state_drain", 32'(dut.state), 32'(FS_DRAIN));
        @(negedge clk); #1;
        chk("t5_state_fetch", 32'(dut.state), 32'(FS_FETCH));
        chk("t5_resume_addr", imem_req_addr, 32'h0000_0200);
        repeat (10) @(negedge clk);
        chk("t5_first_pc", qget(got_pc, 0), 32'h0000_0200);

        // 6a: reset with FIFO non-empty
        reset_dut();
        instr_ready = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk); #1;
        chk("t6_fifo_nonempty", 32'(instr_valid), 1);
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("t6_instr_valid", 32'(instr_valid), 0);
        chk("t6_req_addr", imem_req_addr, 32'h0);
        chk("t6_state", 32'(dut.state), 32'(FS_FETCH));
        chk("t6_fifo_empty", 32'(dut.fifo_empty), 1);
        chk("t6_outstanding", 32'(dut.outstanding), 0);

        // 6b: reset while draining
        @(negedge clk);
        instr_ready = 1'b1;
        clear_logs();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        @(negedge clk);
        redirect_valid = 1'b0; #1;
        chk("t6_in_drain", 32'(dut.state), 32'(FS_DRAIN));
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("t6_drain_state", 32'(dut.state), 32'(FS_FETCH));
        chk("t6_drain_discard", 32'(dut.discard), 0);
        chk("t6_drain_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        clear_logs();
        rst_n = 1'b1;
        repeat (14) @(negedge clk);
        chk("t6_restart_pc", qget(got_pc, 0), 32'h0);

        // 6c: PC wrap from 0xFFFF_FFFC
        reset_dut();
        lat = 1;
        rst_n = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
        chk("t6_wrap_R_no_req", 32'(imem_req_valid), 0);
        @(negedge clk);
        redirect_valid = 1'b0; #1;
        chk("t6_wrap_valid", 32'(imem_req_valid), 1);
        chk("t6_wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
        @(negedge clk); #1;
        chk("t6_wrap_addr1", imem_req_addr, 32'h0000_0000);
        repeat (6) @(negedge clk);
        chk("t6_wrap_pc0", qget(got_pc, 0), 32'hFFFF_FFFC);
        chk("t6_wrap_pc1", qget(got_pc, 1), 32'h0000_0000);

        chk("no_fifo_overflow", 32'(ovf), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
